// File: rtl/im_loader.sv
// im_loader: streams a program image (2-byte big-endian word count N, then N
// 32-bit words MSB first) from a byte valid/ready handshake into the
// instruction memory write port. The CPU is held in reset until the whole
// image has been written.
//
// Optional feature macro: IM_LOADER_CSUM_EN
//   When defined, one trailing checksum byte follows the image. It must equal
//   the XOR of every preceding image byte, header included. A match ends in
//   DONE and a mismatch ends in ERR. The port list is the same either way.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   rx_valid      rx_data carries a byte
//   rx_data[7:0]  image byte
//   rx_ready      byte accepted this cycle when rx_valid is also high
//   reload        one-cycle pulse, restarts the load from DONE or ERR
//   im_we         IM write strobe, one cycle per word
//   im_addr       IM word address
//   im_din        IM write data
//   cpu_hold      1 keeps the CPU in reset
//   done          image loaded, CPU released (sticky until reload)
//   err           load aborted (sticky until reload)
//   words_loaded  words written in the current load
module im_loader #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned BASE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              reload,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_din,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  // Number of words that fit between BASE and the top of the IM.
  localparam int unsigned LIMIT = (2 ** ADDR_W) - BASE;
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_DATA,
`ifdef IM_LOADER_CSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  // State entered once every word is written (or straight after an N==0 header).
`ifdef IM_LOADER_CSUM_EN
  localparam state_t S_FIN = S_CSUM;
`else
  localparam state_t S_FIN = S_DONE;
`endif

  state_t            state, state_d;
  logic [CNT_W-1:0]  n_words, n_d;
  logic [1:0]        byte_cnt, bc_d;
  logic [23:0]       word_sh, sh_d;
  logic [7:0]        hdr_hi, hi_d;
  logic              last_wr, last_d;
  logic              rx_ready_d, we_d, hold_d, done_d, err_d;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       din_d;
  logic [CNT_W-1:0]  wl_d;
  logic [15:0]       hdr_n;
  logic              xfer;

  assign xfer  = rx_valid & rx_ready;
  assign hdr_n = {hdr_hi, rx_data};

`ifdef IM_LOADER_CSUM_EN
  // Running XOR of every accepted byte; restarts on the first header byte.
  logic [7:0] csum;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum <= 8'h00;
    end else if (xfer) begin
      csum <= (state == S_HDR0) ? rx_data : (csum ^ rx_data);
    end
  end
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d = state;
    n_d     = n_words;
    bc_d    = byte_cnt;
    sh_d    = word_sh;
    hi_d    = hdr_hi;
    wl_d    = words_loaded;
    addr_d  = im_addr;
    din_d   = im_din;
    we_d    = 1'b0;
    last_d  = 1'b0;

    case (state)
      S_HDR0: begin
        if (xfer) begin
          hi_d    = rx_data;
          state_d = S_HDR1;
        end
      end
      S_HDR1: begin
        if (xfer) begin
          if (32'(hdr_n) > LIMIT) begin
            state_d = S_ERR;
          end else begin
            n_d     = CNT_W'(hdr_n);
            state_d = (hdr_n == 16'd0) ? S_FIN : S_DATA;
          end
        end
      end
      S_DATA: begin
        // last_wr marks the write cycle of the final word; no byte is taken then.
        if (last_wr) begin
          state_d = S_FIN;
        end else if (xfer) begin
          if (byte_cnt == 2'd3) begin
            we_d   = 1'b1;
            din_d  = {word_sh, rx_data};
            addr_d = BASE_A + words_loaded[ADDR_W-1:0];
            wl_d   = words_loaded + CNT_W'(1);
            bc_d   = 2'd0;
            last_d = (wl_d == n_words);
          end else begin
            sh_d = {word_sh[15:0], rx_data};
            bc_d = byte_cnt + 2'd1;
          end
        end
      end
`ifdef IM_LOADER_CSUM_EN
      S_CSUM: begin
        if (xfer) begin
          state_d = (rx_data == csum) ? S_DONE : S_ERR;
        end
      end
`endif
      S_DONE, S_ERR: begin
        if (reload) begin
          state_d = S_HDR0;
          wl_d    = '0;
          addr_d  = BASE_A;
          bc_d    = 2'd0;
        end
      end
      default: state_d = S_ERR;
    endcase

    rx_ready_d = !last_d && (state_d != S_DONE) && (state_d != S_ERR);
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
    hold_d     = !done_d;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_HDR0;
      n_words      <= '0;
      byte_cnt     <= 2'd0;
      word_sh      <= 24'h0;
      hdr_hi       <= 8'h00;
      last_wr      <= 1'b0;
      rx_ready     <= 1'b0;
      im_we        <= 1'b0;
      im_addr      <= BASE_A;
      im_din       <= 32'h0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
    end else begin
      state        <= state_d;
      n_words      <= n_d;
      byte_cnt     <= bc_d;
      word_sh      <= sh_d;
      hdr_hi       <= hi_d;
      last_wr      <= last_d;
      rx_ready     <= rx_ready_d;
      im_we        <= we_d;
      im_addr      <= addr_d;
      im_din       <= din_d;
      cpu_hold     <= hold_d;
      done         <= done_d;
      err          <= err_d;
      words_loaded <= wl_d;
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader (ADDR_W=4, BASE=0). A byte-level model derives every
// expected IM write and the running word count from the image format alone;
// a negedge process compares them each cycle. Directed tests pin final status.
module tb_im_loader;
  localparam int unsigned AW = 4;
  localparam int unsigned BS = 0;

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          reload;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_din;
  logic          cpu_hold;
  logic          done;
  logic          err;
  logic [AW:0]   words_loaded;

  im_loader #(.ADDR_W(AW), .BASE(BS)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .reload(reload), .im_we(im_we), .im_addr(im_addr),
    .im_din(im_din), .cpu_hold(cpu_hold), .done(done), .err(err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model state: bytes accepted in this load, header, pending write.
  int          k = 0;
  int          mwords = 0;
  logic [7:0]  h0 = 8'h00, h1 = 8'h00;
  logic [31:0] sh = 32'h0;
  bit          pend = 1'b0;
  logic [AW-1:0] paddr = '0;
  logic [31:0] pdata = 32'h0;
  int          mp;
  bit          cmp_en = 1'b0;

  logic [31:0] wr_data[$];
  int          wr_addr[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xsum(input bq_t q);
    logic [7:0] s;
    s = 8'h00;
    foreach (q[i]) s ^= q[i];
    return s;
  endfunction

  // Byte-level model: after the 2-byte header, every 4th byte of word index < N
  // must produce a write in the following cycle.
  always @(posedge clk) begin
    if (!rst) begin
      k = 0; mwords = 0; pend = 1'b0;
    end else begin
      pend = 1'b0;
      if (rx_valid && rx_ready) begin
        if (k == 0) h0 = rx_data;
        else if (k == 1) h1 = rx_data;
        else begin
          mp = k - 2;
          sh = {sh[23:0], rx_data};
          if ((mp % 4 == 3) && (mp / 4 < int'({h0, h1}))) begin
            pend  = 1'b1;
            paddr = AW'(BS + mp / 4);
            pdata = sh;
            mwords++;
          end
        end
        k++;
      end
    end
  end

  // Per-cycle compare against the model, plus a log of all IM writes.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("im_we", 32'(im_we), 32'(pend));
      if (pend) begin
        chk("im_addr", 32'(im_addr), 32'(paddr));
        chk("im_din", im_din, pdata);
      end
      chk("words_loaded", 32'(words_loaded), 32'(mwords));
    end
    if (im_we) begin
      wr_data.push_back(im_din);
      wr_addr.push_back(int'(im_addr));
    end
  end

  task automatic send(input logic [7:0] b, input bit gap, input bit rl);
    bit got;
    got = 1'b0;
    rx_valid = 1'b1; rx_data = b; reload = rl;
    for (int i = 0; i < 50 && !got; i++) begin
      got = rx_ready;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    if (gap) begin @(posedge clk); #1; end
    reload = 1'b0;
    if (!got) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=no_accept expected=accept byte=%h", b);
    end
  endtask

  task automatic send_img(input bq_t q, input bit gap, input int rl_at);
    foreach (q[i]) send(q[i], gap, (i == rl_at) || (rl_at < 0 && 1'b0));
  endtask

  task automatic wait_end(input string name, input bit ed, input bit ee, input int ewl);
    bit fin;
    fin = 1'b0;
    for (int i = 0; i < 40 && !fin; i++) begin
      fin = done | err;
      if (!fin) begin @(posedge clk); #1; end
    end
    @(negedge clk);
    chk({name, "_done"}, 32'(done), 32'(ed));
    chk({name, "_err"}, 32'(err), 32'(ee));
    chk({name, "_hold"}, 32'(cpu_hold), 32'(!ed));
    chk({name, "_ready"}, 32'(rx_ready), 32'(0));
    chk({name, "_wl"}, 32'(words_loaded), 32'(ewl));
  endtask

  task automatic do_reload(input string name);
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    k = 0; mwords = 0; pend = 1'b0;
    @(negedge clk);
    chk({name, "_rl_done"}, 32'(done), 32'(0));
    chk({name, "_rl_err"}, 32'(err), 32'(0));
    chk({name, "_rl_hold"}, 32'(cpu_hold), 32'(1));
    chk({name, "_rl_wl"}, 32'(words_loaded), 32'(0));
    chk({name, "_rl_ready"}, 32'(rx_ready), 32'(1));
  endtask

  task automatic chk_reset_vals(input string name);
    @(negedge clk);
    chk({name, "_ready0"}, 32'(rx_ready), 32'(0));
    chk({name, "_we"}, 32'(im_we), 32'(0));
    chk({name, "_addr"}, 32'(im_addr), 32'(BS));
    chk({name, "_din"}, im_din, 32'h0);
    chk({name, "_hold"}, 32'(cpu_hold), 32'(1));
    chk({name, "_done"}, 32'(done), 32'(0));
    chk({name, "_err"}, 32'(err), 32'(0));
    chk({name, "_wl"}, 32'(words_loaded), 32'(0));
    @(negedge clk);
    chk({name, "_ready1"}, 32'(rx_ready), 32'(1));
  endtask

  bq_t t1, t3, t4, t16, t6;
  int  base_n;
  bit  csum_on;

  initial begin
`ifdef IM_LOADER_CSUM_EN
    csum_on = 1'b1;
`else
    csum_on = 1'b0;
`endif
    rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; reload = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    rst = 1'b1;
    chk_reset_vals("reset");

    // Pin the checksum rule with hand-computed values.
    t1 = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    t6 = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
    chk("xsum_t1", 32'(xsum(t1)), 32'h02);
    chk("xsum_t6", 32'(xsum(t6)), 32'h05);
    if (csum_on) begin
      t1.push_back(8'h02);
    end

    // Test 1: two-word image, back-to-back bytes.
    base_n = wr_data.size();
    send_img(t1, 1'b0, -1);
    wait_end("t1", 1'b1, 1'b0, 2);
    chk("t1_nwr", 32'(wr_data.size() - base_n), 32'd2);
    if (wr_data.size() >= base_n + 2) begin
      chk("t1_w0", wr_data[base_n], 32'h12345678);
      chk("t1_a0", 32'(wr_addr[base_n]), 32'd0);
      chk("t1_w1", wr_data[base_n + 1], 32'h9ABCDEF0);
      chk("t1_a1", 32'(wr_addr[base_n + 1]), 32'd1);
    end

    // Test 2: rx_valid toggling; reload held high across one data transfer and gap.
    do_reload("t2");
    base_n = wr_data.size();
    send_img(t1, 1'b1, 5);
    wait_end("t2", 1'b1, 1'b0, 2);
    chk("t2_nwr", 32'(wr_data.size() - base_n), 32'd2);
    if (wr_data.size() >= base_n + 2) begin
      chk("t2_w1", wr_data[base_n + 1], 32'h9ABCDEF0);
    end

    // Test 3: empty image.
    do_reload("t3");
    t3 = '{8'h00, 8'h00};
    if (csum_on) t3.push_back(8'h00);
    base_n = wr_data.size();
    send_img(t3, 1'b0, -1);
    wait_end("t3", 1'b1, 1'b0, 0);
    chk("t3_nwr", 32'(wr_data.size() - base_n), 32'd0);

    // Test 4: 17 words cannot fit a 16-word IM.
    do_reload("t4");
    t4 = '{8'h00, 8'h11};
    base_n = wr_data.size();
    send_img(t4, 1'b0, -1);
    wait_end("t4", 1'b0, 1'b1, 0);
    chk("t4_nwr", 32'(wr_data.size() - base_n), 32'd0);
    do_reload("t4b");

    // Boundary: exactly 16 words fills the IM.
    t16 = '{8'h00, 8'h10};
    for (int i = 0; i < 64; i++) t16.push_back(8'(i * 7 + 3));
    if (csum_on) t16.push_back(xsum(t16));
    base_n = wr_data.size();
    send_img(t16, 1'b0, -1);
    wait_end("t16", 1'b1, 1'b0, 16);
    chk("t16_nwr", 32'(wr_data.size() - base_n), 32'd16);
    if (wr_data.size() >= base_n + 16) begin
      chk("t16_a15", 32'(wr_addr[base_n + 15]), 32'd15);
      chk("t16_w15", wr_data[base_n + 15], {8'(60*7+3), 8'(61*7+3), 8'(62*7+3), 8'(63*7+3)});
    end

    // Test 6: one-word image; reload during a data transfer is ignored.
    do_reload("t6");
    if (csum_on) t6.push_back(8'h05);
    base_n = wr_data.size();
    send_img(t6, 1'b1, 3);
    wait_end("t6", 1'b1, 1'b0, 1);
    chk("t6_nwr", 32'(wr_data.size() - base_n), 32'd1);
    if (wr_data.size() >= base_n + 1) begin
      chk("t6_w0", wr_data[base_n], 32'h01020304);
    end
    if (csum_on) begin
      do_reload("t6e");
      t6[6] = 8'h04;
      base_n = wr_data.size();
      send_img(t6, 1'b0, -1);
      wait_end("t6e", 1'b0, 1'b1, 1);
      chk("t6e_nwr", 32'(wr_data.size() - base_n), 32'd1);
    end

    // Test 5: reset after six data bytes, then reload the image from scratch.
    do_reload("t5");
    for (int i = 0; i < 8; i++) send(t1[i], 1'b0, 1'b0);
    rst = 1'b0;
    k = 0; mwords = 0; pend = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    chk_reset_vals("t5_rst");
    base_n = wr_data.size();
    send_img(t1, 1'b0, -1);
    wait_end("t5", 1'b1, 1'b0, 2);
    chk("t5_nwr", 32'(wr_data.size() - base_n), 32'd2);
    if (wr_data.size() >= base_n + 2) begin
      chk("t5_a0", 32'(wr_addr[base_n]), 32'd0);
      chk("t5_w0", wr_data[base_n], 32'h12345678);
    end

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
